// File: rtl/sp_pkg.sv
// ---------------------------------------------------------------------------
// sp_pkg
// Shared definitions for the serial-to-parallel receive alignment controller.
//   SP_COMMA / SP_IDLE : default comma and idle-fill characters
//   state_t            : controller states (SEARCH, COUNT, LOCKED)
//   is_ctrl()          : true when a byte is one of the two control characters
// ---------------------------------------------------------------------------
package sp_pkg;

  localparam logic [7:0] SP_COMMA = 8'hBC;
  localparam logic [7:0] SP_IDLE  = 8'h7C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // The control characters can be overridden per instance, so callers pass
  // their own values; the package defaults are used when they do not.
  function automatic logic is_ctrl(input logic [7:0] b,
                                   input logic [7:0] comma = SP_COMMA,
                                   input logic [7:0] idle  = SP_IDLE);
    return (b == comma) || (b == idle);
  endfunction

endpackage

// File: rtl/sp_shift_window.sv
// ---------------------------------------------------------------------------
// sp_shift_window
// Serial history register and byte window. Bits arrive LSB first, so each new
// bit enters at the top and older bits move toward bit 0.
// Ports:
//   clk_i  : bit clock
//   rst_ni : asynchronous active-low reset
//   data_i : serial bit sampled on this edge
//   win_o  : byte completed by the current edge, {data_i, shreg[7:1]}
// ---------------------------------------------------------------------------
module sp_shift_window (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  output logic [7:0] win_o
);

  // Only shreg[7:1] ever reaches the window; bit 0 of the byte-wide shift
  // register would be shifted out unseen, so it is not stored.
  logic [7:1] shreg_q;

  assign win_o = {data_i, shreg_q[7:1]};

  // Shift one bit per edge; the window itself becomes the new history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= 7'h00;
    end else begin
      shreg_q <= win_o[7:1];
    end
  end

endmodule

// File: rtl/sp_sync_controller.sv
// ---------------------------------------------------------------------------
// sp_sync_controller
// Receive-side byte alignment and lock controller. Hunts for the comma
// character in the serial stream, confirms alignment over LOCK_COUNT
// consecutive aligned commas, then frames bytes for the parallel logic.
// Ports:
//   clk_32f   : bit clock, one serial bit per rising edge
//   reset     : asynchronous active-low reset
//   data_in   : serial bit, LSB of each byte first
//   data_out  : last framed byte
//   valid_out : one-cycle strobe for a new non-control byte
//   IDLE_OUT  : high when unlocked or last framed byte was COMMA/IDLE
//   locked    : high while in LOCKED
//   bit_cnt   : bit position within the current byte
// Build option:
//   SP_LOSS_OF_SYNC_EN : drop lock after MAX_GAP boundary bytes with no comma.
//                        Without it LOCKED is left only through reset.
// ---------------------------------------------------------------------------
module sp_sync_controller
  import sp_pkg::*;
#(
  parameter logic [7:0] COMMA      = SP_COMMA,
  parameter logic [7:0] IDLE       = SP_IDLE,
  parameter int         LOCK_COUNT = 4,
  parameter int         MAX_GAP    = 16
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       IDLE_OUT,
  output logic       locked,
  output logic [2:0] bit_cnt
);

  localparam logic [3:0] LockTarget = 4'(LOCK_COUNT);

  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
    $error("sp_sync_controller: LOCK_COUNT must be in 1..15");
  end
  if (MAX_GAP < 2 || MAX_GAP > 255) begin : g_bad_max_gap
    $error("sp_sync_controller: MAX_GAP must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [3:0] commaCnt_q, commaCnt_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] dataOut_q, dataOut_d;
  logic       valid_q, valid_d;
  logic       idle_q, idle_d;
  logic [7:0] win;
  logic       winIsComma;
  logic       atBoundary;

`ifdef SP_LOSS_OF_SYNC_EN
  localparam logic [7:0] GapLimit = 8'(MAX_GAP);
  logic [7:0] gapCnt_q, gapCnt_d;
`endif

  sp_shift_window u_window (
    .clk_i  (clk_32f),
    .rst_ni (reset),
    .data_i (data_in),
    .win_o  (win)
  );

  assign winIsComma = (win == COMMA);
  // The edge that samples bit 7 of a byte completes it.
  assign atBoundary = (bitCnt_q == 3'd7);

  // State, counters and output registers.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      commaCnt_q <= 4'd0;
      bitCnt_q   <= 3'd0;
      dataOut_q  <= 8'h00;
      valid_q    <= 1'b0;
      idle_q     <= 1'b1;
`ifdef SP_LOSS_OF_SYNC_EN
      gapCnt_q   <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      commaCnt_q <= commaCnt_d;
      bitCnt_q   <= bitCnt_d;
      dataOut_q  <= dataOut_d;
      valid_q    <= valid_d;
      idle_q     <= idle_d;
`ifdef SP_LOSS_OF_SYNC_EN
      gapCnt_q   <= gapCnt_d;
`endif
    end
  end

  // Next-state logic. bit_cnt free-runs everywhere and is only re-phased by a
  // comma seen while searching; misaligned commas in COUNT/LOCKED are ignored.
  always_comb begin
    state_d    = state_q;
    commaCnt_d = commaCnt_q;
    bitCnt_d   = bitCnt_q + 3'd1;
`ifdef SP_LOSS_OF_SYNC_EN
    gapCnt_d   = 8'd0;
`endif
    case (state_q)
      SEARCH: begin
        if (winIsComma) begin
          bitCnt_d   = 3'd0;
          commaCnt_d = 4'd1;
          state_d    = (LockTarget == 4'd1) ? LOCKED : COUNT;
        end
      end
      COUNT: begin
        if (atBoundary) begin
          if (winIsComma) begin
            commaCnt_d = commaCnt_q + 4'd1;
            if (commaCnt_d == LockTarget) begin
              state_d = LOCKED;
            end
          end else begin
            commaCnt_d = 4'd0;
            state_d    = SEARCH;
          end
        end
      end
      LOCKED: begin
`ifdef SP_LOSS_OF_SYNC_EN
        gapCnt_d = gapCnt_q;
        if (atBoundary) begin
          if (winIsComma) begin
            gapCnt_d = 8'd0;
          end else if (gapCnt_q + 8'd1 == GapLimit) begin
            gapCnt_d   = 8'd0;
            commaCnt_d = 4'd0;
            state_d    = SEARCH;
          end else begin
            gapCnt_d = gapCnt_q + 8'd1;
          end
        end
`else
        state_d = LOCKED;
`endif
      end
      default: begin
        commaCnt_d = 4'd0;
        state_d    = SEARCH;
      end
    endcase
  end

  // Output register next values. Keying IDLE_OUT on state_d covers both the
  // unlocked states and the byte on which lock is lost: that byte is neither
  // framed nor strobed.
  always_comb begin
    dataOut_d = dataOut_q;
    valid_d   = 1'b0;
    idle_d    = idle_q;
    if (state_d != LOCKED) begin
      idle_d = 1'b1;
    end else if (state_q == LOCKED && atBoundary) begin
      dataOut_d = win;
      valid_d   = !is_ctrl(win, COMMA, IDLE);
      idle_d    = is_ctrl(win, COMMA, IDLE);
    end
  end

  assign data_out  = dataOut_q;
  assign valid_out = valid_q;
  assign IDLE_OUT  = idle_q;
  assign locked    = (state_q == LOCKED);
  assign bit_cnt   = bitCnt_q;

endmodule

// File: tb/tb_sp_sync_controller.sv
// ---------------------------------------------------------------------------
// tb_sp_sync_controller
// Bench for sp_sync_controller. A reference model built from the stream's bit
// history predicts every output on every edge; directed byte sequences pin
// the lock timing and framing literally, then random byte streams with
// occasional bit slips and long data bursts exercise the rest.
// Honours SP_LOSS_OF_SYNC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sp_sync_controller;

  localparam logic [7:0] Comma     = 8'hBC;
  localparam logic [7:0] Idle      = 8'h7C;
  localparam int         LockCount = 4;
  localparam int         MaxGap    = 16;

  localparam int Hunting  = 0;
  localparam int Counting = 1;
  localparam int Locked   = 2;

  logic       clk = 1'b0;
  logic       rstN;
  logic       dataIn;
  logic [7:0] dataOut;
  logic       validOut;
  logic       idleOut;
  logic       lockedOut;
  logic [2:0] bitCnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: bit history plus alignment bookkeeping.
  logic       histQ[$];
  int         edgeNum;
  int         alignEdge;
  int         commaRun;
  int         gapRun;
  int         mode;
  logic [7:0] expData;
  logic       expValid;
  logic       expIdle;
  logic [2:0] expBitCnt;

  always #5 clk = ~clk;

  sp_sync_controller #(
    .COMMA      (Comma),
    .IDLE       (Idle),
    .LOCK_COUNT (LockCount),
    .MAX_GAP    (MaxGap)
  ) dut (
    .clk_32f   (clk),
    .reset     (rstN),
    .data_in   (dataIn),
    .data_out  (dataOut),
    .valid_out (validOut),
    .IDLE_OUT  (idleOut),
    .locked    (lockedOut),
    .bit_cnt   (bitCnt)
  );

  // Hard stop in case something stalls the stimulus.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: run did not finish, got no end, required end within 2 ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic modelReset();
    histQ.delete();
    edgeNum   = 0;
    alignEdge = 0;
    commaRun  = 0;
    gapRun    = 0;
    mode      = Hunting;
    expData   = 8'h00;
    expValid  = 1'b0;
    expIdle   = 1'b1;
    expBitCnt = 3'd0;
  endtask

  // Last eight bits received, oldest in bit 0; zeros before enough history.
  function automatic logic [7:0] currentWindow();
    logic [7:0] w;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = histQ.size() - 8 + i;
      if (idx >= 0) w[i] = histQ[idx];
    end
    return w;
  endfunction

  // Boundaries fall every 8 edges after the edge of the last search match.
  task automatic modelStep(input logic b);
    logic [7:0] w;
    logic       atBoundary;
    logic       dropped;
    histQ.push_back(b);
    if (histQ.size() > 8) void'(histQ.pop_front());
    w          = currentWindow();
    edgeNum    = edgeNum + 1;
    atBoundary = ((edgeNum - alignEdge) % 8) == 0;
    dropped    = 1'b0;
    expValid   = 1'b0;
    if (mode == Hunting) begin
      if (w == Comma) begin
        alignEdge = edgeNum;
        commaRun  = 1;
        mode      = (LockCount == 1) ? Locked : Counting;
      end
    end else if (mode == Counting) begin
      if (atBoundary) begin
        if (w == Comma) begin
          commaRun = commaRun + 1;
          if (commaRun == LockCount) mode = Locked;
        end else begin
          commaRun = 0;
          mode     = Hunting;
        end
      end
    end else begin
      if (atBoundary) begin
`ifdef SP_LOSS_OF_SYNC_EN
        if (w == Comma) begin
          gapRun = 0;
        end else begin
          gapRun = gapRun + 1;
          if (gapRun == MaxGap) begin
            dropped = 1'b1;
            gapRun  = 0;
            mode    = Hunting;
          end
        end
`endif
        if (!dropped) begin
          expData  = w;
          expValid = (w != Comma) && (w != Idle);
          expIdle  = !expValid;
        end
      end
    end
    if (mode != Locked) expIdle = 1'b1;
    expBitCnt = 3'((edgeNum - alignEdge) % 8);
  endtask

  // Compare every output against the model once per edge.
  task automatic checkOutput();
    logic [14:0] act;
    logic [14:0] exp;
    logic        expLocked;
    expLocked = (mode == Locked);
    act = {dataOut, validOut, idleOut, lockedOut, bitCnt};
    exp = {expData, expValid, expIdle, expLocked, expBitCnt};
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL model edge=%0d: got data=%h valid=%b idle=%b locked=%b bitcnt=%0d, want data=%h valid=%b idle=%b locked=%b bitcnt=%0d",
               edgeNum, dataOut, validOut, idleOut, lockedOut, bitCnt,
               expData, expValid, expIdle, expLocked, expBitCnt);
    end
  endtask

  task automatic pinCheck(input string name, input logic [7:0] actual, input logic [7:0] want);
    checks = checks + 1;
    if (actual !== want) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, want);
    end
  endtask

  // Drive one bit (and reset level) away from the sampling edge, let the
  // model see the same edge, then compare shortly after it.
  task automatic applyStimulus(input logic b, input logic r);
    @(negedge clk);
    dataIn = b;
    rstN   = r;
    @(posedge clk);
    if (!rstN) modelReset();
    else       modelStep(dataIn);
    #1;
    checkOutput();
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) applyStimulus(v[i], 1'b1);
  endtask

  initial begin
    logic [7:0] commaBits;
    commaBits = Comma;
    rstN   = 1'b1;
    dataIn = 1'b0;
    modelReset();
    #1 rstN = 1'b0;

    // Held in reset with a toggling line.
    for (int i = 0; i < 40; i++) applyStimulus(i[0], 1'b0);
    pinCheck("reset data_out", dataOut, 8'h00);
    pinCheck("reset valid_out", 8'(validOut), 8'd0);
    pinCheck("reset IDLE_OUT", 8'(idleOut), 8'd1);
    pinCheck("reset locked", 8'(lockedOut), 8'd0);
    pinCheck("reset bit_cnt", 8'(bitCnt), 8'd0);

    // Three offset bits, then commas; lock lands on the 4th comma's last bit.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) sendByte(Comma);
    for (int i = 0; i < 7; i++) applyStimulus(commaBits[i], 1'b1);
    pinCheck("locked before 4th comma end", 8'(lockedOut), 8'd0);
    applyStimulus(commaBits[7], 1'b1);
    pinCheck("locked on 4th comma", 8'(lockedOut), 8'd1);
    pinCheck("IDLE_OUT at lock", 8'(idleOut), 8'd1);
    pinCheck("bit_cnt at lock", 8'(bitCnt), 8'd0);
    for (int i = 0; i < 4; i++) sendByte(Comma);
    pinCheck("valid after commas", 8'(validOut), 8'd0);

    // Idle fill keeps lock, no strobes.
    sendByte(Idle);
    pinCheck("idle data_out", dataOut, 8'h7C);
    pinCheck("idle valid_out", 8'(validOut), 8'd0);
    pinCheck("idle IDLE_OUT", 8'(idleOut), 8'd1);
    for (int i = 0; i < 4; i++) sendByte(Idle);

    // Data bytes strobe once each.
    sendByte(8'hA5);
    pinCheck("A5 data_out", dataOut, 8'hA5);
    pinCheck("A5 valid_out", 8'(validOut), 8'd1);
    pinCheck("A5 IDLE_OUT", 8'(idleOut), 8'd0);
    applyStimulus(1'b0, 1'b1);
    pinCheck("valid one cycle", 8'(validOut), 8'd0);
    for (int i = 1; i < 8; i++) applyStimulus(i[2] | i[1] ? (8'h3C >> i) & 8'h01 : 1'b0, 1'b1);
    pinCheck("3C data_out", dataOut, 8'h3C);
    pinCheck("3C valid_out", 8'(validOut), 8'd1);

    // Asynchronous reset between edges while locked.
    #2 rstN = 1'b0;
    #1;
    pinCheck("async reset locked", 8'(lockedOut), 8'd0);
    pinCheck("async reset IDLE_OUT", 8'(idleOut), 8'd1);
    pinCheck("async reset data_out", dataOut, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);

    // A bad byte during COUNT restarts the comma run.
    sendByte(Comma);
    sendByte(Comma);
    sendByte(8'h55);
    for (int i = 0; i < 3; i++) sendByte(Comma);
    pinCheck("no lock after 3 fresh commas", 8'(lockedOut), 8'd0);
    sendByte(Comma);
    pinCheck("relock on 4th fresh comma", 8'(lockedOut), 8'd1);

    // Long run of data with no comma.
    for (int i = 0; i < 15; i++) sendByte(8'h5A);
    pinCheck("locked after 15 data bytes", 8'(lockedOut), 8'd1);
    sendByte(8'h5A);
`ifdef SP_LOSS_OF_SYNC_EN
    pinCheck("lock lost on 16th byte", 8'(lockedOut), 8'd0);
    pinCheck("IDLE_OUT after loss", 8'(idleOut), 8'd1);
    pinCheck("no valid on lost byte", 8'(validOut), 8'd0);
`else
    pinCheck("lock kept on 16th byte", 8'(lockedOut), 8'd1);
    pinCheck("valid on 16th byte", 8'(validOut), 8'd1);
`endif

    // Random byte stream with bit slips and comma-free bursts.
    for (int k = 0; k < 400; k++) begin
      int extra;
      int pick;
      extra = 0;
      if ($urandom_range(0, 15) == 0) extra = $urandom_range(1, 7);
      for (int j = 0; j < extra; j++) applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 19) == 0) begin
        for (int j = 0; j < 20; j++) sendByte(8'($urandom_range(0, 255)));
      end else begin
        pick = $urandom_range(0, 9);
        if (pick < 4)      sendByte(Comma);
        else if (pick < 6) sendByte(Idle);
        else               sendByte(8'($urandom_range(0, 255)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
